// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_pkg                                                     |
// | Description : Shared types and encodings for the multicycle RV32I control. |
// |               MULTICYCLE_CTRL_TRAP_EN adds the TRAP state.                 |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package core_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef MULTICYCLE_CTRL_TRAP_EN
        , S_TRAP   = 4'd11
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_FUNCT = 2'b11
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] IMM_I      = 2'b00;
    localparam logic [1:0] IMM_S      = 2'b01;
    localparam logic [1:0] IMM_B      = 2'b10;
    localparam logic [1:0] IMM_J      = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       adr_src;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        logic       illegal;
`endif
    } moore_t;

    function automatic moore_t moore_outputs(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.mem_req    = 1'b1;
                m.adr_src    = ADR_PC;
                m.result_src = RES_ALU;
                m.alu_src_a  = SRCA_PC;
                m.alu_src_b  = SRCB_FOUR;
                m.alu_op     = ALUOP_ADD;
            end
            S_DECODE: begin
                m.alu_src_a = SRCA_OLDPC;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                m.alu_src_a = SRCA_RS1;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                m.mem_req = 1'b1;
                m.adr_src = ADR_ALUOUT;
            end
            S_MEMWB: begin
                m.result_src = RES_RDATA;
                m.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                m.mem_req   = 1'b1;
                m.mem_write = 1'b1;
                m.adr_src   = ADR_ALUOUT;
            end
            S_EXECR: begin
                m.alu_src_a = SRCA_RS1;
                m.alu_src_b = SRCB_RS2;
                m.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                m.alu_src_a = SRCA_RS1;
                m.alu_src_b = SRCB_IMM;
                m.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                m.result_src = RES_ALUOUT;
                m.reg_write  = 1'b1;
            end
            S_BEQ: begin
                m.alu_src_a  = SRCA_RS1;
                m.alu_src_b  = SRCB_RS2;
                m.alu_op     = ALUOP_SUB;
                m.result_src = RES_ALUOUT;
            end
            S_JAL: begin
                m.alu_src_a  = SRCA_OLDPC;
                m.alu_src_b  = SRCB_FOUR;
                m.alu_op     = ALUOP_ADD;
                m.result_src = RES_ALUOUT;
                m.pc_write   = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: m.illegal = 1'b1;
`endif
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control_if                                        |
// | Description : Instruction fields, status and datapath controls bundle.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] ula_control;
    logic       illegal_instr;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
               result_src, alu_src_a, alu_src_b, imm_src, ula_control, illegal_instr
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  mem_req, adr_src, ir_write, pc_write, reg_write, mem_write,
               result_src, alu_src_a, alu_src_b, imm_src, ula_control, illegal_instr
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_decoder                                                  |
// | Description : ALU operation code from FSM request and funct fields.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module alu_decoder
    import core_pkg::*;
(
    input  var alu_op_t    alu_op_i,
    input  wire logic [2:0] funct3_i,
    input  wire logic       funct7b5_i,
    input  wire logic       op5_i,
    output logic [2:0]      ula_control_o,
    output logic            illegal_o
);

    always_comb begin
        ula_control_o = ALU_AND;
        illegal_o     = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: ula_control_o = ALU_ADD;
            ALUOP_SUB: ula_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // op5 separates R-type from I-type so addi never turns into sub
                    3'b000:  ula_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  ula_control_o = ALU_SLT;
                    3'b110:  ula_control_o = ALU_OR;
                    3'b111:  ula_control_o = ALU_AND;
                    default: begin
                        ula_control_o = ALU_ADD;
                        illegal_o     = 1'b1;
                    end
                endcase
            end
            default: ula_control_o = ALU_AND;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control                                           |
// | Description : Main FSM of the multicycle RV32I core; MULTICYCLE_CTRL_TRAP_EN|
// |               traps unknown opcodes/funct3 and drives illegal_instr.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module multicycle_control
    import core_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            reset,
    multicycle_control_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    moore_t     out_q;
    alu_op_t    w_alu_op;
    logic [2:0] w_ula;
    logic       w_dec_illegal;
    logic       w_mem_done;
    logic       w_fetch_done;

    assign w_mem_done   = out_q.mem_req && bus.mem_ready;
    assign w_fetch_done = (state_q == S_FETCH) && w_mem_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (w_mem_done) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (w_mem_done) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (w_mem_done) state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_EXECR, S_EXECI: state_d = w_dec_illegal ? S_TRAP : S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
`else
            S_EXECR, S_EXECI: state_d = S_ALUWB;
`endif
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            out_q   <= moore_outputs(S_FETCH);
        end else begin
            state_q <= state_d;
            out_q   <= moore_outputs(state_d);
        end
    end

    assign w_alu_op = reset ? ALUOP_NONE : out_q.alu_op;

    alu_decoder u_alu_decoder (
        .alu_op_i      (w_alu_op),
        .funct3_i      (bus.funct3),
        .funct7b5_i    (bus.funct7b5),
        .op5_i         (bus.opcode[5]),
        .ula_control_o (w_ula),
        .illegal_o     (w_dec_illegal)
    );

    // Reset masks every output so an in-flight access is dropped immediately
    assign bus.mem_req     = !reset && out_q.mem_req;
    assign bus.adr_src     = !reset && out_q.adr_src;
    assign bus.ir_write    = !reset && w_fetch_done;
    assign bus.pc_write    = !reset && (w_fetch_done || out_q.pc_write ||
                                        ((state_q == S_BEQ) && bus.zero));
    assign bus.reg_write   = !reset && out_q.reg_write;
    assign bus.mem_write   = !reset && out_q.mem_write;
    assign bus.result_src  = reset ? 2'b00 : out_q.result_src;
    assign bus.alu_src_a   = reset ? 2'b00 : out_q.alu_src_a;
    assign bus.alu_src_b   = reset ? 2'b00 : out_q.alu_src_b;
    assign bus.imm_src     = (!reset && ((state_q == S_DECODE) || (state_q == S_MEMADR)))
                             ? imm_sel(bus.opcode) : IMM_I;
    assign bus.ula_control = w_ula;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign bus.illegal_instr = !reset && out_q.illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal  = w_dec_illegal;
    assign bus.illegal_instr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I subset core. It sequences the shared 32-bit ALU, instruction/data memory, register file and PC across FETCH/DECODE/EXECUTE/MEM/WB steps, and emits the 3-bit `ula_control` code the ALU consumes. It sits between the instruction register (opcode/funct fields), the ALU zero flag and the memory handshake on one side, and the datapath mux selects and write strobes on the other.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; FSM to FETCH.
- `opcode` input 7: `instr[6:0]` from the instruction register.
- `funct3` input 3: `instr[14:12]`.
- `funct7b5` input 1: `instr[30]`.
- `zero` input 1: ALU result equals zero.
- `mem_ready` input 1: memory completed the current access this cycle.
- `mem_req` output 1: memory access request; held until `mem_ready`.
- `adr_src` output 1: 0 = PC, 1 = ALU-out register.
- `ir_write`, `pc_write`, `reg_write`, `mem_write` output 1 each: write strobes.
- `result_src` output 2: 00 ALU-out register, 01 read data, 10 live ALU result.
- `alu_src_a` output 2: 00 PC, 01 old PC, 10 rs1.
- `alu_src_b` output 2: 00 rs2, 01 immediate, 10 constant 4.
- `imm_src` output 2: 00 I, 01 S, 10 B, 11 J.
- `ula_control` output 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `illegal_instr` output 1: high in TRAP (macro only, else tied 0).

## Operation
- Supported: lw, sw, R-type (add, sub, and, or, slt), I-ALU (addi, andi, ori, slti), beq, jal.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- FETCH: `mem_req`=1, `adr_src`=0, src_a=00, src_b=10, ADD, `result_src`=10. When `mem_ready`: `ir_write`=1, `pc_write`=1, go DECODE; else stay.
- DECODE: src_a=01, src_b=01, ADD (branch target precompute), `imm_src` from opcode. Next: lw/sw→MEMADR, R→EXECR, I→EXECI, beq→BEQ, jal→JAL, else TRAP (macro) or FETCH.
- MEMADR: src_a=10, src_b=01, ADD; `imm_src` I for lw, S for sw; → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: `mem_req`=1, `adr_src`=1; on `mem_ready` → MEMWB. MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1; on `mem_ready` → FETCH.
- EXECR: src_a=10, src_b=00, funct decode. EXECI: src_a=10, src_b=01, funct decode (never SUB). Both → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
- BEQ: src_a=10, src_b=00, SUB, `result_src`=00, `pc_write`=`zero` → FETCH.
- JAL: src_a=01, src_b=10, ADD, `result_src`=00, `pc_write`=1 → ALUWB.
- Funct decode: 000 → SUB if R-type and `funct7b5`, else ADD; 010 → SLT; 110 → OR; 111 → AND; other funct3 → TRAP (macro) or ADD.
- Unlisted outputs are 0 in every state.

## Timing
- Moore outputs from the state register; `ir_write`, `pc_write` (FETCH), state advance are qualified combinationally by `mem_ready`; BEQ `pc_write` by `zero`.
- Zero-wait latencies: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles. Each memory wait cycle adds one.
- While `reset`=1: all outputs 0 (including `mem_req`), `ula_control`=000. First cycle after release is FETCH.
- Reset mid-access: request dropped, no strobe asserted, restart at FETCH.
- `mem_ready` while `mem_req`=0 is ignored.

## Configuration
- `MULTICYCLE_CTRL_TRAP_EN` defined: unknown opcode or funct3 → TRAP; TRAP holds, all strobes 0, `illegal_instr`=1, exits only on `reset`.
- Undefined: unknown opcode returns DECODE→FETCH (NOP, 2 cycles); unknown funct3 uses ADD; `illegal_instr` constant 0; TRAP state absent.

## Structure
- Shared package `core_pkg`: state enum, opcode constants, ALU code constants (AND/OR/ADD/SUB/SLT), mux-select encodings.
- Sub-module `alu_decoder`: combinational ALU code from (alu_op, funct3, funct7b5, opcode[5]) plus illegal flag; FSM supplies alu_op (ADD/SUB/funct).

## Test plan
- add x3,x1,x2 with `mem_ready`=1 constant → FETCH, DECODE, EXECR (`ula_control`=010), ALUWB (`reg_write`=1), back to FETCH in 4 cycles.
- lw with `mem_ready` low 2 cycles in MEMREAD → `mem_req`/`adr_src`=1 held 3 cycles, MEMWB `result_src`=01, total 7 cycles.
- beq with `zero`=1 then `zero`=0 → BEQ `ula_control`=110, `pc_write`=1 then 0, 3 cycles each.
- sub (funct7b5=1) → 110; addi with funct7b5=1 → 010; slti → 111; ori → 001.
- `reset` asserted in MEMWRITE → next cycle all outputs 0, no `mem_write`; after release FETCH with `mem_req`=1.
- opcode 0x7F: with macro → TRAP, `illegal_instr`=1 held; without → FETCH two cycles after fetch completes.
